videobox_pixclk_gen: RTL

VIDEOBOX_PIXCLK_GEN -- requirements
Module: videobox_pixclk_gen

---
 rtl/videobox_pixclk_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/videobox_pixclk_gen.sv
// videobox_pixclk_gen: NUM_CH phase-accumulator pixel-clock generators on refclk.
// Ports: refclk, rst (sync, active-low); cfg_valid/cfg_ready/cfg_ch/cfg_inc/cfg_phase
// load one channel; ch_en runs channels; outclk, outclk_ce, locked, locked_all per channel.
module videobox_pixclk_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC =
    {2'b01, {(ACC_W-2){1'b0}}},
  localparam int unsigned CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_ce,
  output logic [NUM_CH-1:0] locked,
  output logic              locked_all
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [ACC_W-1:0] HALF =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LOCK_MAX =
    CNT_W'(LOCK_CYCLES);

  typedef enum logic {IDLE, LOAD} state_e;

  state_e           state_q;
  logic             ready_q;
  logic [CH_W-1:0]  ch_q;
  logic [ACC_W-1:0] inc_cap_q;
  logic [ACC_W-1:0] phase_cap_q;
  logic [ACC_W-1:0] inc_sat_d;

  // Anything at or above f_ref/2 is clamped to f_ref/2.
  assign inc_sat_d = cfg_inc[ACC_W-1] ? HALF : cfg_inc;

  // Config FSM: ready is registered and only high in IDLE,
  // which limits acceptance to one request per two cycles.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      ch_q        <= '0;
      inc_cap_q   <= DEFAULT_INC;
      phase_cap_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (cfg_valid && ready_q) begin
            state_q     <= LOAD;
            ready_q     <= 1'b0;
            ch_q        <= cfg_ch;
            inc_cap_q   <= inc_sat_d;
            phase_cap_q <= cfg_phase;
          end
        end
        LOAD: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = ready_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ce_q;
    logic             lock_q;
    logic [ACC_W:0]   acc_d;
    logic             hit;

    assign acc_d = {1'b0, acc_q} + {1'b0, inc_q};
    // Out-of-range channel numbers match no generate index.
    assign hit = (state_q == LOAD) && (ch_q == CH_W'(g));

    always_ff @(posedge refclk) begin
      if (!rst) begin
        acc_q  <= '0;
        inc_q  <= DEFAULT_INC;
        cnt_q  <= '0;
        ce_q   <= 1'b0;
        lock_q <= 1'b0;
      end else if (hit) begin
        acc_q  <= phase_cap_q;
        inc_q  <= inc_cap_q;
        cnt_q  <= '0;
        ce_q   <= 1'b0;
        lock_q <= 1'b0;
      end else if (!ch_en[g]) begin
        cnt_q  <= '0;
        ce_q   <= 1'b0;
        lock_q <= 1'b0;
      end else begin
        acc_q <= acc_d[ACC_W-1:0];
        ce_q  <= acc_d[ACC_W];
        if (ce_q && (cnt_q != LOCK_MAX))
          cnt_q <= cnt_q + 1'b1;
        lock_q <= (cnt_q == LOCK_MAX);
      end
    end

    assign outclk[g]    = acc_q[ACC_W-1];
    assign outclk_ce[g] = ce_q;
    assign locked[g]    = lock_q;
  end

  assign locked_all = &locked;

endmodule
